// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } lsu_state_t;

    // RV32I Funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// slave = the LSU itself, master = the pipeline/memory environment around it.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DATA_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] WrData;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport slave (
        input  in_valid, MemRead, MemWrite, Funct3, Addr, WrData, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output in_valid, MemRead, MemWrite, Funct3, Addr, WrData, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data/strobe steering and request
// legality for the incoming request, plus load lane extraction/extension
// for the access currently in flight.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            i_st_funct3,
    input  logic [1:0]            i_st_addr_lo,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_st_wdata,
    output logic [STRB_WIDTH-1:0] o_st_wstrb,
    output logic                  o_req_err,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_ld_data
);

    logic [DATA_WIDTH-1:0] w_lane;
    logic                  w_legal_f3;
    logic                  w_misalign;

    // Replicate store data across lanes and enable only the addressed bytes
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_st_wdata = i_wr_data;
        o_st_wstrb = '0;
        case (i_st_funct3)
            F3_B: begin
                o_st_wdata = {4{i_wr_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_addr_lo;
            end
            F3_H: begin
                o_st_wdata = {2{i_wr_data[15:0]}};
                o_st_wstrb = 4'b0011 << i_st_addr_lo;
            end
            F3_W:    o_st_wstrb = 4'b1111;
            default: o_st_wstrb = '0;
        endcase
    end

    // Flag conflicting ops, unsupported sizes and misaligned halfword/word accesses
    always_comb begin
        w_legal_f3 = 1'b0;
        case (i_st_funct3)
            F3_B, F3_H, F3_W: w_legal_f3 = 1'b1;
            F3_BU, F3_HU:     w_legal_f3 = i_mem_read & ~i_mem_write;
            default:          w_legal_f3 = 1'b0;
        endcase
        // Funct3[1:0] is the size for every legal encoding: 01 half, 10 word
        w_misalign = ((i_st_funct3[1:0] == 2'b01) && i_st_addr_lo[0]) ||
                     ((i_st_funct3[1:0] == 2'b10) && (i_st_addr_lo != 2'b00));
        o_req_err  = (i_mem_read & i_mem_write) | ~w_legal_f3 | w_misalign;
    end

    // Shift the addressed lane down and sign/zero extend by access size
    always_comb begin
        w_lane = i_rd_data >> {i_ld_addr_lo, 3'b000};
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_BU:   o_ld_data = {24'h0, w_lane[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_lane[15:0]};
            default: o_ld_data = w_lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from EX, runs a req/ack
// handshake with data memory, and returns a one-cycle response pulse.
// The pipeline is stalled (in_ready low) for the whole access.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   lsu_bus
);

    lsu_state_t            r_state;
    lsu_state_t            w_next_state;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [DATA_WIDTH-1:0] w_st_wdata;
    logic [STRB_WIDTH-1:0] w_st_wstrb;
    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_accept;

    lsu_align u_align (
        .i_st_funct3  (lsu_bus.Funct3),
        .i_st_addr_lo (lsu_bus.Addr[1:0]),
        .i_mem_read   (lsu_bus.MemRead),
        .i_mem_write  (lsu_bus.MemWrite),
        .i_wr_data    (lsu_bus.WrData),
        .o_st_wdata   (w_st_wdata),
        .o_st_wstrb   (w_st_wstrb),
        .o_req_err    (w_req_err),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_rd_data    (lsu_bus.mem_rdata),
        .o_ld_data    (w_ld_data)
    );

    assign w_accept = (r_state == IDLE) & lsu_bus.in_valid &
                      (lsu_bus.MemRead | lsu_bus.MemWrite);

    // State register plus request/response latches
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr     <= lsu_bus.Addr;
                r_funct3   <= lsu_bus.Funct3;
                r_we       <= lsu_bus.MemWrite;
                r_wdata    <= lsu_bus.MemWrite ? w_st_wdata : '0;
                r_wstrb    <= lsu_bus.MemWrite ? w_st_wstrb : '0;
                r_rsp_data <= '0;
                r_rsp_err  <= w_req_err;
            end else if ((r_state == MEM) && lsu_bus.mem_ack) begin
                // Stores complete with zero data
                r_rsp_data <= r_we ? '0 : w_ld_data;
            end
        end
    end

    // Next-state and output decode; reset forces every output low
    always_comb begin
        w_next_state      = r_state;
        lsu_bus.in_ready  = 1'b0;
        lsu_bus.mem_req   = 1'b0;
        lsu_bus.mem_we    = 1'b0;
        lsu_bus.mem_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
        lsu_bus.mem_wdata = r_wdata;
        lsu_bus.mem_wstrb = r_wstrb;
        lsu_bus.rsp_valid = 1'b0;
        lsu_bus.rsp_data  = '0;
        lsu_bus.rsp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                lsu_bus.in_ready = 1'b1;
                if (w_accept) w_next_state = w_req_err ? RESP : MEM;
            end
            MEM: begin
                lsu_bus.mem_req = 1'b1;
                lsu_bus.mem_we  = r_we;
                if (lsu_bus.mem_ack) w_next_state = RESP;
            end
            RESP: begin
                lsu_bus.rsp_valid = 1'b1;
                lsu_bus.rsp_data  = r_rsp_data;
                lsu_bus.rsp_err   = r_rsp_err;
                w_next_state      = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (reset) begin
            lsu_bus.in_ready  = 1'b0;
            lsu_bus.mem_req   = 1'b0;
            lsu_bus.mem_we    = 1'b0;
            lsu_bus.mem_addr  = '0;
            lsu_bus.mem_wdata = '0;
            lsu_bus.mem_wstrb = '0;
            lsu_bus.rsp_valid = 1'b0;
            lsu_bus.rsp_data  = '0;
            lsu_bus.rsp_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, error responses,
// delayed acknowledge and reset during a memory access.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    load_store_unit_if lsu_bus ();

    load_store_unit dut (
        .clk     (clk),
        .reset   (reset),
        .lsu_bus (lsu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        lsu_bus.in_valid = 1'b1;
        lsu_bus.MemRead  = rd;
        lsu_bus.MemWrite = wr;
        lsu_bus.Funct3   = f3;
        lsu_bus.Addr     = a;
        lsu_bus.WrData   = wd;
        #1;
        check("in_ready_before_accept", {31'b0, lsu_bus.in_ready}, 32'd1);
        tick();
        lsu_bus.in_valid = 1'b0;
        lsu_bus.MemRead  = 1'b0;
        lsu_bus.MemWrite = 1'b0;
    endtask

    // Zero-wait acknowledge in the current MEM cycle
    task automatic ack(input logic [31:0] rdata);
        lsu_bus.mem_ack   = 1'b1;
        lsu_bus.mem_rdata = rdata;
        tick();
        lsu_bus.mem_ack   = 1'b0;
        lsu_bus.mem_rdata = '0;
    endtask

    // Check the response pulse now, then that it lasts exactly one cycle
    task automatic expect_rsp(input string tag, input logic [31:0] data, input logic err);
        check({tag, "_rsp_valid"}, {31'b0, lsu_bus.rsp_valid}, 32'd1);
        check({tag, "_rsp_data"},  lsu_bus.rsp_data, data);
        check({tag, "_rsp_err"},   {31'b0, lsu_bus.rsp_err}, {31'b0, err});
        tick();
        check({tag, "_rsp_drop"},  {31'b0, lsu_bus.rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, lsu_bus.in_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset             = 1'b1;
        lsu_bus.in_valid  = 1'b1;
        lsu_bus.MemRead   = 1'b0;
        lsu_bus.MemWrite  = 1'b1;
        lsu_bus.Funct3    = F3_W;
        lsu_bus.Addr      = 32'h0000_0104;
        lsu_bus.WrData    = 32'h1111_2222;
        lsu_bus.mem_ack   = 1'b0;
        lsu_bus.mem_rdata = '0;

        // Reset: request presented but ignored, all outputs low
        tick();
        tick();
        check("rst_in_ready",  {31'b0, lsu_bus.in_ready},  32'd0);
        check("rst_mem_req",   {31'b0, lsu_bus.mem_req},   32'd0);
        check("rst_mem_addr",  lsu_bus.mem_addr,           32'd0);
        check("rst_mem_wstrb", {28'b0, lsu_bus.mem_wstrb}, 32'd0);
        check("rst_rsp_valid", {31'b0, lsu_bus.rsp_valid}, 32'd0);
        lsu_bus.in_valid = 1'b0;
        lsu_bus.MemWrite = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, lsu_bus.in_ready}, 32'd1);

        // SW 0x100
        issue(1'b0, 1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_mem_req",  {31'b0, lsu_bus.mem_req},   32'd1);
        check("sw_mem_we",   {31'b0, lsu_bus.mem_we},    32'd1);
        check("sw_in_ready", {31'b0, lsu_bus.in_ready},  32'd0);
        check("sw_mem_addr", lsu_bus.mem_addr,           32'h0000_0100);
        check("sw_wstrb",    {28'b0, lsu_bus.mem_wstrb}, 32'hF);
        check("sw_wdata",    lsu_bus.mem_wdata,          32'hDEAD_BEEF);
        ack(32'h0);
        expect_rsp("sw", 32'h0, 1'b0);

        // LB 0x103, top byte 0x80 -> sign extended
        issue(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0);
        check("lb_mem_we",   {31'b0, lsu_bus.mem_we},    32'd0);
        check("lb_mem_addr", lsu_bus.mem_addr,           32'h0000_0100);
        check("lb_wstrb",    {28'b0, lsu_bus.mem_wstrb}, 32'h0);
        ack(32'h80FF_1234);
        expect_rsp("lb", 32'hFFFF_FF80, 1'b0);

        // LBU same address/data -> zero extended
        issue(1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0);
        ack(32'h80FF_1234);
        expect_rsp("lbu", 32'h0000_0080, 1'b0);

        // SH 0x102 -> upper lanes
        issue(1'b0, 1'b1, F3_H, 32'h0000_0102, 32'h0000_ABCD);
        check("sh_mem_addr", lsu_bus.mem_addr,           32'h0000_0100);
        check("sh_wstrb",    {28'b0, lsu_bus.mem_wstrb}, 32'hC);
        check("sh_wdata",    lsu_bus.mem_wdata,          32'hABCD_ABCD);
        ack(32'h0);
        expect_rsp("sh", 32'h0, 1'b0);

        // SB 0x101 -> lane 1
        issue(1'b0, 1'b1, F3_B, 32'h0000_0101, 32'h1234_5677);
        check("sb_wstrb", {28'b0, lsu_bus.mem_wstrb}, 32'h2);
        check("sb_wdata", lsu_bus.mem_wdata,          32'h7777_7777);
        ack(32'h0);
        expect_rsp("sb", 32'h0, 1'b0);

        // LHU / LH 0x102
        issue(1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0);
        ack(32'hABCD_0000);
        expect_rsp("lhu", 32'h0000_ABCD, 1'b0);
        issue(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0);
        ack(32'hABCD_0000);
        expect_rsp("lh", 32'hFFFF_ABCD, 1'b0);

        // LW misaligned: error response at t+1, no memory request
        issue(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0);
        check("lw_mis_mem_req", {31'b0, lsu_bus.mem_req}, 32'd0);
        expect_rsp("lw_mis", 32'h0, 1'b1);

        // SH at odd address, store with BU encoding, read+write together
        issue(1'b0, 1'b1, F3_H, 32'h0000_0103, 32'h0);
        expect_rsp("sh_mis", 32'h0, 1'b1);
        issue(1'b0, 1'b1, F3_BU, 32'h0000_0100, 32'h0);
        expect_rsp("sbu_illegal", 32'h0, 1'b1);
        issue(1'b1, 1'b1, F3_W, 32'h0000_0100, 32'h0);
        expect_rsp("rd_wr_both", 32'h0, 1'b1);

        // in_valid without an op is not a transaction
        lsu_bus.in_valid = 1'b1;
        tick();
        lsu_bus.in_valid = 1'b0;
        check("noop_mem_req",  {31'b0, lsu_bus.mem_req},   32'd0);
        check("noop_rsp",      {31'b0, lsu_bus.rsp_valid}, 32'd0);
        check("noop_in_ready", {31'b0, lsu_bus.in_ready},  32'd1);

        // LW with acknowledge delayed 5 cycles
        issue(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("wait_mem_req",  {31'b0, lsu_bus.mem_req},   32'd1);
            check("wait_mem_addr", lsu_bus.mem_addr,           32'h0000_0300);
            check("wait_in_ready", {31'b0, lsu_bus.in_ready},  32'd0);
            check("wait_rsp",      {31'b0, lsu_bus.rsp_valid}, 32'd0);
            tick();
        end
        ack(32'h1234_5678);
        check("lw_wait_mem_req_drop", {31'b0, lsu_bus.mem_req}, 32'd0);
        expect_rsp("lw_wait", 32'h1234_5678, 1'b0);

        // Reset while in MEM abandons the access
        issue(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0);
        check("rmem_mem_req", {31'b0, lsu_bus.mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("rmem_req_drop",  {31'b0, lsu_bus.mem_req},  32'd0);
        check("rmem_in_ready",  {31'b0, lsu_bus.in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rmem_ready_back", {31'b0, lsu_bus.in_ready},  32'd1);
        check("rmem_no_rsp",     {31'b0, lsu_bus.rsp_valid}, 32'd0);
        tick();
        check("rmem_no_rsp_2",   {31'b0, lsu_bus.rsp_valid}, 32'd0);
        check("rmem_no_req_2",   {31'b0, lsu_bus.mem_req},   32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
